// File: rtl/apb_regbank_slave.sv
// APB4 completer terminating the bus in a bank of NREGS registers.
// Wait states, byte-strobe writes, read-only masking, privileged filtering
// and PSLVERR. Register contents and write pulses go to local hardware.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no transfer in progress; a setup phase moves to S_ACCESS
// S_ACCESS | access phase; wait counter runs down, completes at zero
module apb_regbank_slave #(
  parameter int                     DATAWIDTH   = 32,
  parameter int                     ADDRWIDTH   = 32,
  parameter int                     NREGS       = 16,
  parameter logic [ADDRWIDTH-1:0]   BASEADDR    = '0,
  parameter int                     WAIT_STATES = 0,
  parameter logic [NREGS-1:0]       RO_MASK     = '0,
  parameter bit                     PRIV_ONLY   = 1'b0
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [ADDRWIDTH-1:0]       paddr,
  input  logic [2:0]                 pprot,
  input  logic                       pselx,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATAWIDTH-1:0]       pwdata,
  input  logic [DATAWIDTH/8-1:0]     pstrb,
  output logic                       pready,
  output logic [DATAWIDTH-1:0]       prdata,
  output logic                       pslverr,
  output logic [NREGS*DATAWIDTH-1:0] regs_q,
  input  logic [NREGS*DATAWIDTH-1:0] ro_data,
  output logic [NREGS-1:0]           wr_pulse
);

  localparam int         NBYTES = DATAWIDTH / 8;
  localparam int         LSB    = (NBYTES > 1) ? $clog2(NBYTES) : 0;
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [NREGS*DATAWIDTH-1:0] regs_d;
  logic [NREGS-1:0]           wr_pulse_q, wr_pulse_d;

  logic [ADDRWIDTH-1:0] off, off_word;
  logic                 below, misalign, out_range, priv_err, ro_hit, err;
  logic                 commit;
  logic [DATAWIDTH-1:0] rd_val;
  logic                 unused_pprot;

  // Only the privileged bit of pprot matters here.
  assign unused_pprot = ^pprot[2:1];

  assign off       = paddr - BASEADDR;
  assign off_word  = off >> LSB;
  assign below     = paddr < BASEADDR;
  assign misalign  = (off & ADDRWIDTH'(NBYTES - 1)) != '0;
  assign out_range = off_word >= ADDRWIDTH'(NREGS);
  assign priv_err  = PRIV_ONLY && !pprot[0];
  assign err       = below | misalign | out_range | priv_err | (pwrite & ro_hit);

  // Outputs are held low while reset is asserted, even mid-transfer.
  assign pready   = presetn && (state_q == S_ACCESS) && pselx && penable && (cnt_q == 4'd0);
  assign pslverr  = pready & err;
  assign prdata   = (pready && !err && !pwrite) ? rd_val : '0;
  assign commit   = pready & pwrite & ~err;
  assign wr_pulse = wr_pulse_q;

  // Read mux: RO registers return the hardware-supplied value.
  always_comb begin
    rd_val = '0;
    ro_hit = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (off_word == ADDRWIDTH'(i)) begin
        ro_hit = RO_MASK[i];
        rd_val = RO_MASK[i] ? ro_data[i*DATAWIDTH +: DATAWIDTH]
                            : regs_q[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // Next state and wait counter; a repeated setup phase restarts the wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pselx && !penable) begin
          state_d = S_ACCESS;
          cnt_d   = WS;
        end
      end
      S_ACCESS: begin
        if (!pselx) begin
          state_d = S_IDLE;
        end else if (!penable) begin
          cnt_d = WS;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte-lane merge on commit; RO slots are never written and stay zero.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (commit && !RO_MASK[i] && off_word == ADDRWIDTH'(i)) begin
        wr_pulse_d[i] = 1'b1;
        for (int b = 0; b < NBYTES; b++) begin
          if (pstrb[b]) regs_d[i*DATAWIDTH + b*8 +: 8] = pwdata[b*8 +: 8];
        end
      end
    end
  end

  // State, counter, register bank and pulse flops with synchronous reset.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      regs_q     <= '0;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

endmodule

// File: tb/tb_apb_regbank_slave.sv
module tb_apb_regbank_slave;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [7:0]  RO   = 8'h08;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         presetn = 1'b0;
  logic [31:0]  paddr = '0;
  logic [2:0]   pprot = '0;
  logic         sel0 = 1'b0, sel1 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0]  pwdata = '0;
  logic [3:0]   pstrb = '0;
  logic [255:0] ro_data = '0;

  logic         pready0, pslverr0, pready1, pslverr1;
  logic [31:0]  prdata0, prdata1;
  logic [255:0] regs0, regs1;
  logic [7:0]   wrp0, wrp1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mdl [2][8];

  apb_regbank_slave #(.DATAWIDTH(32), .ADDRWIDTH(32), .NREGS(8), .BASEADDR(BASE),
                      .WAIT_STATES(0), .RO_MASK(RO), .PRIV_ONLY(1'b0)) dut0 (
    .pclk(clk), .presetn(presetn), .paddr(paddr), .pprot(pprot), .pselx(sel0),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready0), .prdata(prdata0), .pslverr(pslverr0), .regs_q(regs0),
    .ro_data(ro_data), .wr_pulse(wrp0));

  apb_regbank_slave #(.DATAWIDTH(32), .ADDRWIDTH(32), .NREGS(8), .BASEADDR(BASE),
                      .WAIT_STATES(3), .RO_MASK(RO), .PRIV_ONLY(1'b1)) dut1 (
    .pclk(clk), .presetn(presetn), .paddr(paddr), .pprot(pprot), .pselx(sel1),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready1), .prdata(prdata1), .pslverr(pslverr1), .regs_q(regs1),
    .ro_data(ro_data), .wr_pulse(wrp1));

  // Bus driver: called #1 after a rising edge, returns #1 after the edge that
  // ends the transfer. abort_at=k drops pselx in access cycle k.
  task automatic apb_xfer(input int d, input logic [31:0] addr, input logic wr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic [2:0] prot, input int abort_at,
                          output logic [31:0] rdata, output logic err, output int waits);
    logic rdy;
    paddr = addr; pwrite = wr; pwdata = data; pstrb = strb; pprot = prot; penable = 1'b0;
    if (d == 0) sel0 = 1'b1; else sel1 = 1'b1;
    rdata = '0; err = 1'b0; waits = 0;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (abort_at == k) begin
        sel0 = 1'b0; sel1 = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      rdy = (d == 0) ? pready0 : pready1;
      if (rdy) begin
        rdata = (d == 0) ? prdata0 : prdata1;
        err   = (d == 0) ? pslverr0 : pslverr1;
        @(posedge clk); #1;
        sel0 = 1'b0; sel1 = 1'b0; penable = 1'b0;
        return;
      end
      waits++;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL xfer_timeout dut%0d addr %h: pready never seen in 40 cycles", d, addr);
    sel0 = 1'b0; sel1 = 1'b0; penable = 1'b0;
  endtask

  // Reference model: applies an access to the array and returns the expected response.
  task automatic model_access(input int d, input logic [31:0] addr, input logic wr,
                              input logic [31:0] data, input logic [3:0] strb,
                              input logic [2:0] prot, output logic exp_err,
                              output logic [31:0] exp_rd, output logic [7:0] exp_pulse);
    logic [7:0] ro_m;
    int idx;
    ro_m = RO;
    exp_rd = '0; exp_pulse = '0; exp_err = 1'b0; idx = 0;
    if (addr < BASE) exp_err = 1'b1;
    else begin
      if ((addr - BASE) % 4 != 0) exp_err = 1'b1;
      if ((addr - BASE) / 4 >= 8) exp_err = 1'b1;
      else idx = int'((addr - BASE) / 4);
    end
    if (d == 1 && prot[0] == 1'b0) exp_err = 1'b1;
    if (!exp_err && wr && ro_m[idx]) exp_err = 1'b1;
    if (!exp_err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) mdl[d][idx][b*8 +: 8] = data[b*8 +: 8];
        exp_pulse[idx] = 1'b1;
      end else begin
        exp_rd = ro_m[idx] ? ro_data[idx*32 +: 32] : mdl[d][idx];
      end
    end
  endtask

  function automatic logic [255:0] exp_vec(input int d);
    logic [255:0] v;
    logic [7:0] ro_m;
    ro_m = RO;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = ro_m[i] ? 32'h0 : mdl[d][i];
    return v;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) mdl[d][i] = '0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pready0, pslverr0, prdata0, pready1, pslverr1, prdata1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy %b/%b err %b/%b rd %h/%h, need all 0",
               pready0, pready1, pslverr0, pslverr1, prdata0, prdata1);
    end
    checks++;
    if (regs0 !== '0 || regs1 !== '0 || wrp0 !== '0 || wrp1 !== '0) begin
      errors++;
      $display("FAIL reset_regs got regs0 %h wrp %h/%h, need 0", regs0, wrp0, wrp1);
    end
    clear_model();
    @(posedge clk); #1;
    presetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er, ee; logic [31:0] erd; logic [7:0] ep; int w;
    apb_xfer(0, BASE + 4, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 0, rd, er, w);
    model_access(0, BASE + 4, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, ee, erd, ep);
    checks++;
    if (w !== 0 || er !== 1'b0) begin
      errors++; $display("FAIL wr_latency got waits %0d err %b, need 0 0", w, er);
    end
    checks++;
    if (regs0[63:32] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_data got %h need deadbeef", regs0[63:32]);
    end
    checks++;
    if (wrp0 !== 8'h02) begin
      errors++; $display("FAIL wr_pulse got %h need 02", wrp0);
    end
    @(posedge clk); #1;
    checks++;
    if (wrp0 !== 8'h00) begin
      errors++; $display("FAIL wr_pulse_width got %h need 00", wrp0);
    end
    apb_xfer(0, BASE + 4, 1'b0, 32'h0, 4'h0, 3'b000, 0, rd, er, w);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL readback got %h err %b need deadbeef 0", rd, er);
    end
    apb_xfer(0, BASE + 4, 1'b1, 32'h11223344, 4'h5, 3'b000, 0, rd, er, w);
    model_access(0, BASE + 4, 1'b1, 32'h11223344, 4'h5, 3'b000, ee, erd, ep);
    checks++;
    if (regs0[63:32] !== 32'hDE22BE44 || wrp0 !== 8'h02) begin
      errors++; $display("FAIL strobe_merge got %h pulse %h need de22be44 02", regs0[63:32], wrp0);
    end
    apb_xfer(0, BASE + 4, 1'b1, 32'hFFFFFFFF, 4'h0, 3'b000, 0, rd, er, w);
    model_access(0, BASE + 4, 1'b1, 32'hFFFFFFFF, 4'h0, 3'b000, ee, erd, ep);
    checks++;
    if (regs0[63:32] !== 32'hDE22BE44 || wrp0 !== 8'h02 || er !== 1'b0) begin
      errors++; $display("FAIL zero_strobe got %h pulse %h err %b need de22be44 02 0", regs0[63:32], wrp0, er);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er, ee; logic [31:0] erd; logic [7:0] ep; int w;
    apb_xfer(1, BASE + 8, 1'b1, 32'hA5A50F0F, 4'hF, 3'b001, 0, rd, er, w);
    model_access(1, BASE + 8, 1'b1, 32'hA5A50F0F, 4'hF, 3'b001, ee, erd, ep);
    checks++;
    if (w !== 3 || er !== 1'b0 || regs1[95:64] !== 32'hA5A50F0F || wrp1 !== 8'h04) begin
      errors++;
      $display("FAIL wait_write got waits %0d err %b reg %h pulse %h need 3 0 a5a50f0f 04",
               w, er, regs1[95:64], wrp1);
    end
    apb_xfer(1, BASE + 8, 1'b1, 32'h0, 4'hF, 3'b001, 2, rd, er, w);
    checks++;
    if (w !== 1 || regs1[95:64] !== 32'hA5A50F0F || wrp1 !== 8'h00) begin
      errors++;
      $display("FAIL abort got waits %0d reg %h pulse %h need 1 a5a50f0f 00", w, regs1[95:64], wrp1);
    end
    @(posedge clk); #1;
    checks++;
    if (regs1[95:64] !== 32'hA5A50F0F || wrp1 !== 8'h00) begin
      errors++; $display("FAIL abort_late got reg %h pulse %h need a5a50f0f 00", regs1[95:64], wrp1);
    end
    apb_xfer(1, BASE + 8, 1'b0, 32'h0, 4'h0, 3'b001, 0, rd, er, w);
    checks++;
    if (w !== 3 || rd !== 32'hA5A50F0F || er !== 1'b0) begin
      errors++; $display("FAIL wait_read got waits %0d rd %h err %b need 3 a5a50f0f 0", w, rd, er);
    end
  endtask

  typedef struct { int d; logic [31:0] addr; logic wr; logic [2:0] prot; } err_case_t;

  task automatic test_errors();
    err_case_t tbl [8];
    logic [31:0] rd, dat, erd; logic er, ee; logic [7:0] ep, pulse; logic [255:0] vec; int w;
    tbl[0] = '{0, BASE + 32, 1'b1, 3'b000};
    tbl[1] = '{0, BASE + 32, 1'b0, 3'b000};
    tbl[2] = '{0, BASE + 2,  1'b0, 3'b000};
    tbl[3] = '{0, BASE + 2,  1'b1, 3'b000};
    tbl[4] = '{0, BASE + 12, 1'b1, 3'b000};
    tbl[5] = '{1, BASE + 8,  1'b1, 3'b110};
    tbl[6] = '{1, BASE + 8,  1'b0, 3'b000};
    tbl[7] = '{0, BASE - 4,  1'b0, 3'b000};
    for (int i = 0; i < 8; i++) begin
      dat = $urandom;
      apb_xfer(tbl[i].d, tbl[i].addr, tbl[i].wr, dat, 4'hF, tbl[i].prot, 0, rd, er, w);
      model_access(tbl[i].d, tbl[i].addr, tbl[i].wr, dat, 4'hF, tbl[i].prot, ee, erd, ep);
      vec   = (tbl[i].d == 0) ? regs0 : regs1;
      pulse = (tbl[i].d == 0) ? wrp0 : wrp1;
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || pulse !== 8'h00 || vec !== exp_vec(tbl[i].d)) begin
        errors++;
        $display("FAIL err_case%0d got err %b rd %h pulse %h need 1 0 00 and no update",
                 i, er, rd, pulse);
      end
    end
  endtask

  task automatic test_ro_read();
    logic [31:0] rd; logic er; int w;
    ro_data[3*32 +: 32] = 32'hCAFEF00D;
    apb_xfer(0, BASE + 12, 1'b0, 32'h0, 4'h0, 3'b000, 0, rd, er, w);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      errors++; $display("FAIL ro_read0 got %h err %b need cafef00d 0", rd, er);
    end
    apb_xfer(1, BASE + 12, 1'b0, 32'h0, 4'h0, 3'b001, 0, rd, er, w);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0 || regs1[127:96] !== 32'h0) begin
      errors++; $display("FAIL ro_read1 got %h err %b slot %h need cafef00d 0 0", rd, er, regs1[127:96]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, dat, erd; logic er, ee; logic [7:0] ep; int w, c0;
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      dat = $urandom;
      apb_xfer(0, BASE + 32'(i * 4), 1'b1, dat, 4'hF, 3'b000, 0, rd, er, w);
      model_access(0, BASE + 32'(i * 4), 1'b1, dat, 4'hF, 3'b000, ee, erd, ep);
    end
    checks++;
    if (cyc - c0 !== 8) begin
      errors++; $display("FAIL b2b_ws0 got %0d cycles need 8", cyc - c0);
    end
    checks++;
    if (regs0 !== exp_vec(0)) begin
      errors++; $display("FAIL b2b_ws0_data got %h need %h", regs0, exp_vec(0));
    end
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      dat = $urandom;
      apb_xfer(1, BASE + 32'(i * 4), 1'b1, dat, 4'hF, 3'b001, 0, rd, er, w);
      model_access(1, BASE + 32'(i * 4), 1'b1, dat, 4'hF, 3'b001, ee, erd, ep);
    end
    checks++;
    if (cyc - c0 !== 15 || regs1 !== exp_vec(1)) begin
      errors++; $display("FAIL b2b_ws3 got %0d cycles need 15 (data ok=%b)", cyc - c0, regs1 === exp_vec(1));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, ee; logic [7:0] ep; int w;
    paddr = BASE + 4; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b001;
    sel1 = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 presetn = 1'b0;
    @(negedge clk);
    checks++;
    if (pready1 !== 1'b0 || pslverr1 !== 1'b0 || prdata1 !== 32'h0) begin
      errors++; $display("FAIL rst_mid_comb got rdy %b err %b rd %h need 0 0 0", pready1, pslverr1, prdata1);
    end
    @(posedge clk); #1;
    clear_model();
    checks++;
    if (regs1 !== '0 || regs0 !== '0 || wrp1 !== '0 || wrp0 !== '0) begin
      errors++; $display("FAIL rst_mid_state got regs1 %h pulse %h need 0", regs1, wrp1);
    end
    presetn = 1'b1; sel1 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    apb_xfer(1, BASE + 4, 1'b1, 32'h0BADF00D, 4'hF, 3'b001, 0, rd, er, w);
    model_access(1, BASE + 4, 1'b1, 32'h0BADF00D, 4'hF, 3'b001, ee, erd, ep);
    checks++;
    if (w !== 3 || er !== 1'b0 || regs1 !== exp_vec(1) || wrp1 !== 8'h02) begin
      errors++; $display("FAIL rst_fresh got waits %0d err %b reg %h pulse %h need 3 0 0badf00d 02",
                         w, er, regs1[63:32], wrp1);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, dat, addr, erd; logic er, ee, wr; logic [7:0] ep, pulse; logic [3:0] strb;
    logic [2:0] prot; logic [255:0] vec; int w, d, idx;
    for (int n = 0; n < 60; n++) begin
      d = int'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 9));
      addr = BASE + 32'(idx * 4);
      if ($urandom_range(0, 7) == 0) addr = addr + 32'd2;
      if ($urandom_range(0, 15) == 0) addr = BASE - 32'd8;
      wr = 1'($urandom_range(0, 1));
      dat = $urandom; strb = 4'($urandom); prot = 3'($urandom);
      ro_data[3*32 +: 32] = $urandom;
      apb_xfer(d, addr, wr, dat, strb, prot, 0, rd, er, w);
      model_access(d, addr, wr, dat, strb, prot, ee, erd, ep);
      vec   = (d == 0) ? regs0 : regs1;
      pulse = (d == 0) ? wrp0 : wrp1;
      checks++;
      if (er !== ee || w !== (d == 0 ? 0 : 3) || (!wr && rd !== erd)) begin
        errors++;
        $display("FAIL rnd%0d_resp dut%0d addr %h wr %b got err %b rd %h waits %0d need err %b rd %h",
                 n, d, addr, wr, er, rd, w, ee, erd);
      end
      checks++;
      if (vec !== exp_vec(d) || pulse !== ep) begin
        errors++;
        $display("FAIL rnd%0d_state dut%0d addr %h got pulse %h need %h regs %h need %h",
                 n, d, addr, pulse, ep, vec, exp_vec(d));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_errors();
    test_ro_read();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
